// File: rtl/posit_regime_pipe_if.sv
// Operand-in / regime-out handshake bundle for the posit regime decoder.
interface posit_regime_pipe_if #(
   parameter int unsigned N  = 32,
   parameter int unsigned RS = $clog2(N)
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_posit;
   logic          out_valid;
   logic          out_ready;
   logic          out_sign;
   logic          out_zero;
   logic          out_nar;
   logic [RS:0]   out_k;
   logic [RS-1:0] out_run;
   logic [N-2:0]  out_rem;

   // Decoder side: consumes words, produces regime results.
   modport slave (
      input  in_valid, in_posit, out_ready,
      output in_ready, out_valid, out_sign, out_zero, out_nar, out_k, out_run, out_rem
   );

   // Producer/consumer side surrounding the decoder.
   modport master (
      output in_valid, in_posit, out_ready,
      input  in_ready, out_valid, out_sign, out_zero, out_nar, out_k, out_run, out_rem
   );
endinterface

// File: rtl/posit_regime_pipe.sv
// Two-stage back-pressurable posit regime decoder: S1 takes |word|, S2 measures the regime run.
module posit_regime_pipe #(
   parameter int unsigned N  = 32,
   parameter int unsigned ES = 4,
   parameter int unsigned RS = $clog2(N)
) (
   input logic                clk,
   input logic                rst_n,
   posit_regime_pipe_if.slave bus
);
   localparam int unsigned BW = N - 1;   // body width below the sign bit
   localparam int unsigned KW = RS + 1;  // signed regime width

   // Exponent width only matters downstream; reject nonsensical shapes at elaboration.
   if (N < 4 || ES >= N) begin : g_param_chk
      $error("posit_regime_pipe: need N >= 4 and ES < N");
   end

   logic          adv1_c, adv2_c;
   logic [BW-1:0] body_c;
   logic          rc_c, hit_end_c, special_c;
   logic [RS-1:0] run_c, len_c;
   logic [KW-1:0] k_c;
   logic [BW-1:0] rem_c;

   logic          v1_q, v1_d, sign1_q, sign1_d, zero1_q, zero1_d, nar1_q, nar1_d;
   logic [BW-1:0] body1_q, body1_d;
   logic          v2_q, v2_d, sign2_q, sign2_d, zero2_q, zero2_d, nar2_q, nar2_d;
   logic [KW-1:0] k2_q, k2_d;
   logic [RS-1:0] run2_q, run2_d;
   logic [BW-1:0] rem2_q, rem2_d;

   // Stage advance: S2 drains when empty or popped; S1 follows S2.
   assign adv2_c       = !v2_q || bus.out_ready;
   assign adv1_c       = !v1_q || adv2_c;
   assign bus.in_ready = adv1_c;

   // Low bits of the two's complement equal the low bits of the full-word negation.
   assign body_c = bus.in_posit[N-1] ? (~bus.in_posit[BW-1:0] + BW'(1)) : bus.in_posit[BW-1:0];

   // Stage 1 capture: sign, special-value flags and magnitude body.
   always_comb begin
      v1_d    = v1_q;
      sign1_d = sign1_q;
      zero1_d = zero1_q;
      nar1_d  = nar1_q;
      body1_d = body1_q;
      if (adv1_c) begin
         v1_d = bus.in_valid;
         if (bus.in_valid) begin
            sign1_d = bus.in_posit[N-1];
            zero1_d = (bus.in_posit == '0);
            nar1_d  = (bus.in_posit == {1'b1, {BW{1'b0}}});
            body1_d = body_c;
         end
      end
   end

   // Regime run length: identical bits from the body MSB down (always at least one).
   always_comb begin
      rc_c      = body1_q[BW-1];
      run_c     = '0;
      hit_end_c = 1'b0;
      for (int i = int'(BW) - 1; i >= 0; i--) begin
         if (!hit_end_c && (body1_q[i] == rc_c)) run_c = run_c + RS'(1);
         else hit_end_c = 1'b1;
      end
   end

   // Regime value, regime length (run plus terminator unless it ran off the end) and remainder.
   always_comb begin
      k_c       = rc_c ? (KW'(run_c) - KW'(1)) : (KW'(0) - KW'(run_c));
      len_c     = (run_c < RS'(BW)) ? (run_c + RS'(1)) : RS'(BW);
      rem_c     = body1_q << len_c;
      special_c = zero1_q || nar1_q;
   end

   // Stage 2 capture: zero/NaR force an all-zero regime payload.
   always_comb begin
      v2_d    = v2_q;
      sign2_d = sign2_q;
      zero2_d = zero2_q;
      nar2_d  = nar2_q;
      k2_d    = k2_q;
      run2_d  = run2_q;
      rem2_d  = rem2_q;
      if (adv2_c) begin
         v2_d = v1_q;
         if (v1_q) begin
            sign2_d = sign1_q;
            zero2_d = zero1_q;
            nar2_d  = nar1_q;
            k2_d    = special_c ? '0 : k_c;
            run2_d  = special_c ? '0 : run_c;
            rem2_d  = special_c ? '0 : rem_c;
         end
      end
   end

   // Pipeline registers; reset drops any in-flight words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         sign1_q <= 1'b0;
         zero1_q <= 1'b0;
         nar1_q  <= 1'b0;
         body1_q <= '0;
         v2_q    <= 1'b0;
         sign2_q <= 1'b0;
         zero2_q <= 1'b0;
         nar2_q  <= 1'b0;
         k2_q    <= '0;
         run2_q  <= '0;
         rem2_q  <= '0;
      end else begin
         v1_q    <= v1_d;
         sign1_q <= sign1_d;
         zero1_q <= zero1_d;
         nar1_q  <= nar1_d;
         body1_q <= body1_d;
         v2_q    <= v2_d;
         sign2_q <= sign2_d;
         zero2_q <= zero2_d;
         nar2_q  <= nar2_d;
         k2_q    <= k2_d;
         run2_q  <= run2_d;
         rem2_q  <= rem2_d;
      end
   end

   assign bus.out_valid = v2_q;
   assign bus.out_sign  = sign2_q;
   assign bus.out_zero  = zero2_q;
   assign bus.out_nar   = nar2_q;
   assign bus.out_k     = k2_q;
   assign bus.out_run   = run2_q;
   assign bus.out_rem   = rem2_q;
endmodule

// File: tb/tb_posit_regime_pipe.sv
// Scoreboard bench for the posit regime decoder at N=8/ES=1 and N=32/ES=4.
module tb_posit_regime_pipe;
   typedef struct packed {
      logic              sign;
      logic              zero;
      logic              nar;
      logic signed [7:0] k;
      logic [5:0]        run;
      logic [30:0]       rem;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   rdy_mode = 1;   // 0: stall, 1: always ready, else random

   exp_t q8[$];
   exp_t q32[$];
   bit   dir8_use = 0, dir32_use = 0;
   exp_t dir8_exp, dir32_exp;
   bit   held8 = 0, held32 = 0;
   exp_t snap8, snap32;

   posit_regime_pipe_if #(.N(8))  if8 ();
   posit_regime_pipe_if #(.N(32)) if32 ();

   posit_regime_pipe #(.N(8),  .ES(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   posit_regime_pipe #(.N(32), .ES(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

   always #5 clk = ~clk;

   function automatic string fmt(input exp_t e);
      return $sformatf("sign=%0d zero=%0d nar=%0d k=%0d run=%0d rem=%h",
                       e.sign, e.zero, e.nar, e.k, e.run, e.rem);
   endfunction

   task automatic chk(input bit ok, input string name, input string detail);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   function automatic exp_t mk(input bit s, input bit z, input bit n, input int k,
                               input int run, input int rem);
      exp_t e;
      e.sign = s; e.zero = z; e.nar = n;
      e.k = 8'(k); e.run = 6'(run); e.rem = 31'(rem);
      return e;
   endfunction

   // Reference: decode the value arithmetically from the posit definition.
   function automatic exp_t ref_decode(input int n, input logic [31:0] w);
      exp_t e;
      longint unsigned mask, bmask, x, a, body, rem;
      int rc, m, k, len;
      mask  = (64'd1 << n) - 64'd1;
      bmask = (64'd1 << (n - 1)) - 64'd1;
      x     = 64'(w) & mask;
      e     = '0;
      e.sign = ((x >> (n - 1)) & 64'd1) != 0;
      if (x == 0) begin
         e.zero = 1'b1;
      end else if (x == (64'd1 << (n - 1))) begin
         e.nar = 1'b1;
      end else begin
         a    = e.sign ? ((mask + 64'd1 - x) & mask) : x;
         body = a & bmask;
         rc   = int'((body >> (n - 2)) & 64'd1);
         m    = 0;
         for (int i = n - 2; i >= 0; i--) begin
            if (int'((body >> i) & 64'd1) == rc) m++;
            else break;
         end
         k    = (rc == 1) ? m - 1 : -m;
         len  = (m < n - 1) ? m + 1 : n - 1;
         rem  = (body << len) & bmask;
         e.k = 8'(k); e.run = 6'(m); e.rem = 31'(rem);
      end
      return e;
   endfunction

   function automatic exp_t act8();
      exp_t a;
      a.sign = if8.out_sign; a.zero = if8.out_zero; a.nar = if8.out_nar;
      a.k = 8'($signed(if8.out_k)); a.run = 6'(if8.out_run); a.rem = 31'(if8.out_rem);
      return a;
   endfunction

   function automatic exp_t act32();
      exp_t a;
      a.sign = if32.out_sign; a.zero = if32.out_zero; a.nar = if32.out_nar;
      a.k = 8'($signed(if32.out_k)); a.run = 6'(if32.out_run); a.rem = 31'(if32.out_rem);
      return a;
   endfunction

   // Output ready driver.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       begin if8.out_ready = 1'b0; if32.out_ready = 1'b0; end
         1:       begin if8.out_ready = 1'b1; if32.out_ready = 1'b1; end
         default: begin
            if8.out_ready  = 1'($urandom_range(0, 1));
            if32.out_ready = 1'($urandom_range(0, 1));
         end
      endcase
   end

   // N=8 scoreboard: record accepted words, check results and stall stability.
   always @(negedge clk) begin
      exp_t a, e;
      if (!rst_n) begin
         held8 = 0;
      end else begin
         if (if8.in_valid && if8.in_ready)
            q8.push_back(dir8_use ? dir8_exp : ref_decode(8, 32'(if8.in_posit)));
         a = act8();
         if (held8)
            chk(if8.out_valid && (a == snap8), "hold8",
                $sformatf("valid=%0d %s required %s", if8.out_valid, fmt(a), fmt(snap8)));
         if (if8.out_valid && if8.out_ready) begin
            if (q8.size() == 0) chk(1'b0, "spurious8", $sformatf("%s with nothing pending", fmt(a)));
            else begin
               e = q8.pop_front();
               chk(a == e, "result8", $sformatf("%s required %s", fmt(a), fmt(e)));
            end
         end
         held8 = if8.out_valid && !if8.out_ready;
         snap8 = a;
      end
   end

   // N=32 scoreboard.
   always @(negedge clk) begin
      exp_t a, e;
      if (!rst_n) begin
         held32 = 0;
      end else begin
         if (if32.in_valid && if32.in_ready)
            q32.push_back(dir32_use ? dir32_exp : ref_decode(32, if32.in_posit));
         a = act32();
         if (held32)
            chk(if32.out_valid && (a == snap32), "hold32",
                $sformatf("valid=%0d %s required %s", if32.out_valid, fmt(a), fmt(snap32)));
         if (if32.out_valid && if32.out_ready) begin
            if (q32.size() == 0) chk(1'b0, "spurious32", $sformatf("%s with nothing pending", fmt(a)));
            else begin
               e = q32.pop_front();
               chk(a == e, "result32", $sformatf("%s required %s", fmt(a), fmt(e)));
            end
         end
         held32 = if32.out_valid && !if32.out_ready;
         snap32 = a;
      end
   end

   task automatic push8(input logic [7:0] w, input bit use_dir, input exp_t e);
      bit acc;
      int cyc;
      acc = 0; cyc = 0;
      if8.in_valid = 1'b1; if8.in_posit = w; dir8_use = use_dir; dir8_exp = e;
      while (!acc && cyc < 200) begin
         @(negedge clk); acc = if8.in_ready;
         @(posedge clk); #1; cyc++;
      end
      if8.in_valid = 1'b0; dir8_use = 0;
      if (!acc) chk(1'b0, "accept8", $sformatf("word %h not taken in %0d cycles", w, cyc));
   endtask

   task automatic push32(input logic [31:0] w, input bit use_dir, input exp_t e);
      bit acc;
      int cyc;
      acc = 0; cyc = 0;
      if32.in_valid = 1'b1; if32.in_posit = w; dir32_use = use_dir; dir32_exp = e;
      while (!acc && cyc < 200) begin
         @(negedge clk); acc = if32.in_ready;
         @(posedge clk); #1; cyc++;
      end
      if32.in_valid = 1'b0; dir32_use = 0;
      if (!acc) chk(1'b0, "accept32", $sformatf("word %h not taken in %0d cycles", w, cyc));
   endtask

   task automatic drain();
      int c;
      c = 0;
      @(negedge clk); rdy_mode = 1;
      while ((q8.size() != 0 || q32.size() != 0) && c < 200) begin
         @(posedge clk); c++;
      end
      chk(q8.size() == 0 && q32.size() == 0, "drain",
          $sformatf("pending8=%0d pending32=%0d required 0/0", q8.size(), q32.size()));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] w8;
      logic [7:0] picks [6];
      picks = '{8'h00, 8'h80, 8'h7F, 8'h01, 8'hFF, 8'h81};
      if8.in_valid = 1'b0;  if8.in_posit = '0;  if8.out_ready = 1'b1;
      if32.in_valid = 1'b0; if32.in_posit = '0; if32.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk(if8.out_valid == 1'b0, "rst_valid8", $sformatf("out_valid=%0d required 0", if8.out_valid));
      chk(if8.in_ready == 1'b1, "rst_ready8", $sformatf("in_ready=%0d required 1", if8.in_ready));
      chk(act8() == '0, "rst_payload8", $sformatf("%s required all zero", fmt(act8())));
      chk(if32.out_valid == 1'b0, "rst_valid32", $sformatf("out_valid=%0d required 0", if32.out_valid));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed N=8 vectors
      push8(8'h6A, 1, mk(0, 0, 0,  1, 2, 7'b1010000));
      push8(8'h96, 1, mk(1, 0, 0,  1, 2, 7'b1010000));
      push8(8'h7F, 1, mk(0, 0, 0,  6, 7, 0));
      push8(8'h01, 1, mk(0, 0, 0, -6, 6, 0));
      push8(8'h40, 1, mk(0, 0, 0,  0, 1, 0));
      push8(8'h00, 1, mk(0, 1, 0,  0, 0, 0));
      push8(8'h80, 1, mk(1, 0, 1,  0, 0, 0));
      drain();

      // Two-cycle latency
      push8(8'h6A, 1, mk(0, 0, 0, 1, 2, 7'b1010000));
      @(negedge clk);
      chk(if8.out_valid == 1'b0, "latency_early", $sformatf("out_valid=%0d required 0", if8.out_valid));
      @(negedge clk);
      chk(if8.out_valid == 1'b1, "latency_two", $sformatf("out_valid=%0d required 1", if8.out_valid));
      drain();

      // Capacity and back-pressure
      @(negedge clk); rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      push8(8'h6A, 0, '0);
      push8(8'h01, 0, '0);
      if8.in_valid = 1'b1; if8.in_posit = 8'h7F;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk(if8.in_ready == 1'b0, "full_stall", $sformatf("in_ready=%0d required 0", if8.in_ready));
      end
      rdy_mode = 1;
      @(negedge clk);
      chk(if8.in_ready == 1'b1 && if8.out_valid == 1'b1, "full_release",
          $sformatf("in_ready=%0d out_valid=%0d required 1/1", if8.in_ready, if8.out_valid));
      @(posedge clk); #1; if8.in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk(if8.out_valid == 1'b1, "no_bubble", $sformatf("out_valid=%0d required 1", if8.out_valid));
      end
      drain();

      // Randomized N=8 traffic with random back-pressure
      @(negedge clk); rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         w8 = ($urandom_range(0, 7) == 0) ? picks[$urandom_range(0, 5)] : 8'($urandom);
         push8(w8, 0, '0);
      end
      drain();

      // Reset with two words in flight
      @(negedge clk); rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      push8(8'h6A, 0, '0);
      push8(8'h01, 0, '0);
      #1 rst_n = 1'b0;
      #1;
      chk(if8.out_valid == 1'b0, "rst_midflight", $sformatf("out_valid=%0d required 0", if8.out_valid));
      q8.delete();
      q32.delete();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; rdy_mode = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk(if8.out_valid == 1'b0, "rst_no_stale", $sformatf("out_valid=%0d required 0", if8.out_valid));
      end
      @(posedge clk); #1;
      push8(8'h6A, 1, mk(0, 0, 0, 1, 2, 7'b1010000));
      drain();

      // N=32 directed and random
      push32(32'h7FFFFFFF, 1, mk(0, 0, 0,  30, 31, 0));
      push32(32'h00000001, 1, mk(0, 0, 0, -30, 30, 0));
      push32(32'h80000000, 1, mk(1, 0, 1,   0,  0, 0));
      push32(32'h00000000, 1, mk(0, 1, 0,   0,  0, 0));
      @(negedge clk); rdy_mode = 2;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         push32($urandom >> $urandom_range(0, 31), 0, '0);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
